// File: rtl/fifo_word_packer.sv
// Packs PACK consecutive words from a show-ahead FIFO read port into one wide
// valid/ready beat. A partial beat goes out on flush or after an idle timeout.
module fifo_word_packer #(
  parameter int unsigned DSIZE   = 32,
  parameter int unsigned PACK    = 4,
  parameter int unsigned CW      = 3,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned TW      = 7
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DSIZE-1:0]        fifo_rdata,
  input  logic                    fifo_empty,
  output logic                    fifo_rinc,
  input  logic                    flush,
  output logic [DSIZE*PACK-1:0]   out_data,
  output logic [PACK-1:0]         out_keep,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CW-1:0]           pack_cnt,
  output logic                    busy
);

  typedef enum logic {S_FILL, S_OUT} state_t;

  state_t                      r_state, w_state_n;
  logic [PACK-1:0][DSIZE-1:0]  r_lanes, w_lanes_n;
  logic [PACK-1:0]             r_keep, w_keep_n;
  logic                        r_valid, w_valid_n;
  logic [CW-1:0]               r_cnt, w_cnt_n;
  logic [TW-1:0]               r_timer, w_timer_n;
  logic                        r_busy, w_busy_n;

  logic                        w_pop;
  logic                        w_tmo;
  logic                        w_go;
  logic [CW-1:0]               w_cnt_inc;

  // Pop request is combinational so the head word is taken in the same cycle it is seen.
  assign fifo_rinc = rst_n & (r_state == S_FILL) & ~fifo_empty;
  assign w_pop     = fifo_rinc;
  assign w_tmo     = (TIMEOUT != 0) && (r_timer == TW'(TIMEOUT));
  assign w_cnt_inc = r_cnt + CW'(w_pop);
  assign w_go      = (w_cnt_inc == CW'(PACK)) || ((flush || w_tmo) && (w_cnt_inc != '0));

  // Next-state and next-output logic for the fill/emit handshake.
  always_comb begin
    w_state_n = r_state;
    w_lanes_n = r_lanes;
    w_keep_n  = r_keep;
    w_valid_n = r_valid;
    w_cnt_n   = r_cnt;
    w_timer_n = r_timer;
    case (r_state)
      S_FILL: begin
        for (int k = 0; k < PACK; k++) begin
          if (w_pop && (r_cnt == CW'(k))) w_lanes_n[k] = fifo_rdata;
        end
        w_cnt_n = w_cnt_inc;
        if (w_pop || (r_cnt == '0)) begin
          w_timer_n = '0;
        end else if (r_timer != TW'(TIMEOUT)) begin
          w_timer_n = r_timer + TW'(1);
        end
        if (w_go) begin
          w_valid_n = 1'b1;
          w_state_n = S_OUT;
          for (int k = 0; k < PACK; k++) begin
            w_keep_n[k] = (CW'(k) < w_cnt_inc);
          end
        end
      end
      S_OUT: begin
        // Beat is held until accepted; then all lanes clear so later partial beats read zero above their count.
        if (r_valid && out_ready) begin
          w_valid_n = 1'b0;
          w_cnt_n   = '0;
          w_lanes_n = '0;
          w_keep_n  = '0;
          w_timer_n = '0;
          w_state_n = S_FILL;
        end
      end
    endcase
    w_busy_n = (w_cnt_n != '0) || w_valid_n;
  end

  // State and output registers; reset discards any buffered words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FILL;
      r_lanes <= '0;
      r_keep  <= '0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
      r_timer <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_lanes <= w_lanes_n;
      r_keep  <= w_keep_n;
      r_valid <= w_valid_n;
      r_cnt   <= w_cnt_n;
      r_timer <= w_timer_n;
      r_busy  <= w_busy_n;
    end
  end

  assign out_data  = r_lanes;
  assign out_keep  = r_keep;
  assign out_valid = r_valid;
  assign pack_cnt  = r_cnt;
  assign busy      = r_busy;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer: the bench plays the show-ahead FIFO and compares
// the DUT every cycle against a queue-based model of the packing rules.
module tb_fifo_word_packer;

  localparam int unsigned DSIZE   = 32;
  localparam int unsigned PACK    = 4;
  localparam int unsigned CW      = 3;
  localparam int unsigned TIMEOUT = 64;
  localparam int unsigned TW      = 7;
  localparam int unsigned DW      = DSIZE * PACK;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DSIZE-1:0]  fifo_rdata;
  logic              fifo_empty;
  logic              fifo_rinc;
  logic              flush;
  logic [DW-1:0]     out_data;
  logic [PACK-1:0]   out_keep;
  logic              out_valid;
  logic              out_ready;
  logic [CW-1:0]     pack_cnt;
  logic              busy;

  fifo_word_packer #(
    .DSIZE(DSIZE), .PACK(PACK), .CW(CW), .TIMEOUT(TIMEOUT), .TW(TW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .fifo_rdata(fifo_rdata), .fifo_empty(fifo_empty), .fifo_rinc(fifo_rinc),
    .flush(flush),
    .out_data(out_data), .out_keep(out_keep), .out_valid(out_valid), .out_ready(out_ready),
    .pack_cnt(pack_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // FIFO contents (head at index 0) and word scoreboard
  logic [DSIZE-1:0] q[$];
  logic [DSIZE-1:0] exp_words[$];
  logic [DSIZE-1:0] got_words[$];

  // Model: words held by the packer, whether a beat is on offer, and its contents
  logic [DSIZE-1:0] m_buf[$];
  bit               m_valid = 1'b0;
  logic [DW-1:0]    m_data  = '0;
  logic [PACK-1:0]  m_keep  = '0;
  int               last_pop = 0;

  // Observation counters
  int               cyc = 0;
  int               rinc_cnt = 0;
  int               beat_cnt = 0;
  int               pop_cyc = 0;
  int               rise_cyc = 0;
  bit               prev_valid = 1'b0;
  logic [DW-1:0]    last_beat_data = '0;
  logic [PACK-1:0]  last_beat_keep = '0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic refresh();
    fifo_empty = (q.size() == 0);
    fifo_rdata = (q.size() != 0) ? q[0] : '0;
  endtask

  task automatic push(input logic [DSIZE-1:0] w);
    q.push_back(w);
    exp_words.push_back(w);
    refresh();
  endtask

  // One clock: compare at negedge, advance the model, then apply the FIFO pop after the edge.
  task automatic step();
    logic [DSIZE-1:0] nb[$];
    bit env_pop;
    bit mpop;
    bit tmo;
    @(negedge clk);
    cyc++;
    mpop = !m_valid && (q.size() != 0);
    chk("rinc", DW'(fifo_rinc), DW'(mpop));
    chk("valid", DW'(out_valid), DW'(m_valid));
    chk("pack_cnt", DW'(pack_cnt), DW'(m_buf.size()));
    chk("busy", DW'(busy), DW'(m_valid || (m_buf.size() != 0)));
    if (m_valid) begin
      chk("data", out_data, m_data);
      chk("keep", DW'(out_keep), DW'(m_keep));
    end
    env_pop = fifo_rinc;
    if (fifo_rinc) begin
      rinc_cnt++;
      pop_cyc = cyc;
    end
    if (out_valid && !prev_valid) rise_cyc = cyc;
    prev_valid = out_valid;
    if (out_valid && out_ready) begin
      beat_cnt++;
      last_beat_data = out_data;
      last_beat_keep = out_keep;
      for (int k = 0; k < PACK; k++) begin
        if (out_keep[k]) got_words.push_back(out_data[k*DSIZE +: DSIZE]);
      end
    end
    // Idle timeout: a buffered partial beat fires once TIMEOUT+1 cycles have passed since its last pop.
    if (!m_valid) begin
      tmo = (TIMEOUT != 0) && (m_buf.size() != 0) && ((cyc - last_pop) >= int'(TIMEOUT) + 1);
      nb = m_buf;
      if (mpop) begin
        nb.push_back(q[0]);
        last_pop = cyc;
      end
      if ((nb.size() == PACK) || ((flush || tmo) && (nb.size() != 0))) begin
        m_valid = 1'b1;
        m_data  = '0;
        m_keep  = '0;
        foreach (nb[k]) begin
          m_data[k*DSIZE +: DSIZE] = nb[k];
          m_keep[k] = 1'b1;
        end
      end
      m_buf = nb;
    end else if (out_ready) begin
      m_valid = 1'b0;
      m_buf.delete();
    end
    @(posedge clk);
    #1;
    if (env_pop) begin
      if (q.size() == 0) chk("pop_of_empty", 1, 0);
      else void'(q.pop_front());
    end
    refresh();
  endtask

  task automatic wait_beats(input int target, input int budget);
    int n = 0;
    while ((beat_cnt < target) && (n < budget)) begin
      step();
      n++;
    end
    chk("beat_wait", DW'(beat_cnt >= target), DW'(1));
  endtask

  task automatic sb_check();
    int n;
    chk("sb_len", DW'(got_words.size()), DW'(exp_words.size()));
    n = (got_words.size() < exp_words.size()) ? got_words.size() : exp_words.size();
    for (int i = 0; i < n; i++) chk("sb_word", DW'(got_words[i]), DW'(exp_words[i]));
  endtask

  initial begin
    int r0;
    int b0;
    logic [DW-1:0] lit;
    rst_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    fifo_empty = 1'b0;
    fifo_rdata = 32'hDEAD_BEEF;
    #12;
    // Reset values, with a non-empty FIFO to show rinc is gated by reset
    chk("rst_valid", DW'(out_valid), 0);
    chk("rst_data", out_data, 0);
    chk("rst_keep", DW'(out_keep), 0);
    chk("rst_cnt", DW'(pack_cnt), 0);
    chk("rst_busy", DW'(busy), 0);
    chk("rst_rinc", DW'(fifo_rinc), 0);
    refresh();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // T1: four words make one full beat
    out_ready = 1'b1;
    r0 = rinc_cnt;
    b0 = beat_cnt;
    push(32'h11); push(32'h22); push(32'h33); push(32'h44);
    wait_beats(b0 + 1, 20);
    lit = 128'h00000044_00000033_00000022_00000011;
    chk("t1_data", last_beat_data, lit);
    chk("t1_keep", DW'(last_beat_keep), DW'(4'b1111));
    chk("t1_rinc", DW'(rinc_cnt - r0), 4);

    // T2: two words then flush gives a half beat
    b0 = beat_cnt;
    push(32'hA); push(32'hB);
    repeat (4) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    wait_beats(b0 + 1, 10);
    lit = 128'h0000000B_0000000A;
    chk("t2_data", last_beat_data, lit);
    chk("t2_keep", DW'(last_beat_keep), DW'(4'b0011));
    chk("t2_cnt", DW'(pack_cnt), 0);

    // T3: lone word leaves on timeout; 65 edges from pop edge to rise edge
    b0 = beat_cnt;
    push(32'h5);
    wait_beats(b0 + 1, 100);
    chk("t3_latency", DW'(rise_cyc - pop_cyc), 66);
    chk("t3_keep", DW'(last_beat_keep), DW'(4'b0001));

    // T4: back-pressure holds beat 1 and leaves four words in the FIFO
    out_ready = 1'b0;
    r0 = rinc_cnt;
    b0 = beat_cnt;
    for (int i = 0; i < 8; i++) push($urandom);
    repeat (20) step();
    chk("t4_fifo_left", DW'(q.size()), 4);
    chk("t4_rinc", DW'(rinc_cnt - r0), 4);
    chk("t4_valid", DW'(out_valid), 1);
    out_ready = 1'b1;
    wait_beats(b0 + 2, 20);

    // T5: flush with nothing buffered is ignored
    flush = 1'b1;
    repeat (3) step();
    chk("t5_valid", DW'(out_valid), 0);
    chk("t5_busy", DW'(busy), 0);
    flush = 1'b0;

    // Random traffic: bursty pushes followed by idle stretches long enough to time out
    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < 160; i++) begin
        if ((i < 80) && ($urandom_range(0, 2) == 0)) push($urandom);
        flush     = ($urandom_range(0, 19) == 0);
        out_ready = ($urandom_range(0, 9) < 7);
        step();
      end
    end
    flush = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if ((q.size() == 0) && !m_valid && (m_buf.size() == 0)) break;
      step();
    end
    flush = 1'b0;
    chk("drain_idle", DW'(busy), 0);
    sb_check();

    // T6: reset mid-beat drops everything at once
    out_ready = 1'b0;
    push(32'h61); push(32'h62); push(32'h63);
    repeat (3) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    push(32'h64); push(32'h65);
    step();
    chk("t6_pre_cnt", DW'(pack_cnt), 3);
    chk("t6_pre_valid", DW'(out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_valid", DW'(out_valid), 0);
    chk("t6_cnt", DW'(pack_cnt), 0);
    chk("t6_rinc", DW'(fifo_rinc), 0);
    chk("t6_busy", DW'(busy), 0);
    q.delete();
    exp_words.delete();
    got_words.delete();
    m_buf.delete();
    m_valid = 1'b0;
    prev_valid = 1'b0;
    refresh();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    b0 = beat_cnt;
    push(32'hC0DE0001); push(32'hC0DE0002); push(32'hC0DE0003); push(32'hC0DE0004);
    wait_beats(b0 + 1, 20);
    lit = 128'hC0DE0004_C0DE0003_C0DE0002_C0DE0001;
    chk("t6_post_data", last_beat_data, lit);
    sb_check();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
